axi_stom_s3: RTL and testbench



---
 rtl/axi_stom_s3.sv | 216 +++++++++++++++++++++
 tb/tb_axi_stom_s3.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_stom_s3.sv
// Response-path mux for one crossbar master port.
// Per-channel round-robin arbiters for B and R from three slaves.

module axi_stom_s3_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req,
  input  logic       done,
  output logic [2:0] grant
);
  typedef enum logic {IDLE, BUSY} state_t;

  state_t     state;
  logic [2:0] gnt;
  logic [2:0] pick;
  logic [1:0] ptr;

  function automatic logic [1:0] next_ptr(input logic [2:0] oh);
    logic [1:0] n;
    unique case (1'b1)
      oh[0]:   n = 2'd1;
      oh[1]:   n = 2'd2;
      default: n = 2'd0;
    endcase
    return n;
  endfunction

  // first requester scanning ptr, ptr+1, ptr+2
  always_comb begin
    pick = 3'b000;
    case (ptr)
      2'd1: begin
        if (req[1])      pick = 3'b010;
        else if (req[2]) pick = 3'b100;
        else if (req[0]) pick = 3'b001;
      end
      2'd2: begin
        if (req[2])      pick = 3'b100;
        else if (req[0]) pick = 3'b001;
        else if (req[1]) pick = 3'b010;
      end
      default: begin
        if (req[0])      pick = 3'b001;
        else if (req[1]) pick = 3'b010;
        else if (req[2]) pick = 3'b100;
      end
    endcase
  end

  // a locked grant is released only by the completing handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= 3'b000;
      ptr   <= 2'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|pick) begin
            if (done) begin
              ptr <= next_ptr(pick);
            end else begin
              state <= BUSY;
              gnt   <= pick;
            end
          end
        end
        BUSY: begin
          if (done) begin
            state <= IDLE;
            ptr   <= next_ptr(gnt);
            gnt   <= 3'b000;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign grant = rst ? 3'b000
               : (state == BUSY) ? gnt : pick;
endmodule

module axi_stom_s3 #(
  parameter logic [1:0] MASTER_ID = 2'b01,
  parameter int WIDTH_CID = 4,
  parameter int WIDTH_ID  = 4,
  parameter int WIDTH_DA  = 32,
  parameter int WIDTH_SID = WIDTH_CID + WIDTH_ID
) (
  input  logic                 ACLK,
  input  logic                 ARESET,
  input  logic [WIDTH_SID-1:0] S0_BID,
  input  logic [1:0]           S0_BRESP,
  input  logic                 S0_BVALID,
  output logic                 S0_BREADY,
  input  logic [WIDTH_SID-1:0] S0_RID,
  input  logic [WIDTH_DA-1:0]  S0_RDATA,
  input  logic [1:0]           S0_RRESP,
  input  logic                 S0_RLAST,
  input  logic                 S0_RVALID,
  output logic                 S0_RREADY,
  input  logic [WIDTH_SID-1:0] S1_BID,
  input  logic [1:0]           S1_BRESP,
  input  logic                 S1_BVALID,
  output logic                 S1_BREADY,
  input  logic [WIDTH_SID-1:0] S1_RID,
  input  logic [WIDTH_DA-1:0]  S1_RDATA,
  input  logic [1:0]           S1_RRESP,
  input  logic                 S1_RLAST,
  input  logic                 S1_RVALID,
  output logic                 S1_RREADY,
  input  logic [WIDTH_SID-1:0] S2_BID,
  input  logic [1:0]           S2_BRESP,
  input  logic                 S2_BVALID,
  output logic                 S2_BREADY,
  input  logic [WIDTH_SID-1:0] S2_RID,
  input  logic [WIDTH_DA-1:0]  S2_RDATA,
  input  logic [1:0]           S2_RRESP,
  input  logic                 S2_RLAST,
  input  logic                 S2_RVALID,
  output logic                 S2_RREADY,
  output logic [WIDTH_ID-1:0]  M_BID,
  output logic [1:0]           M_BRESP,
  output logic                 M_BVALID,
  input  logic                 M_BREADY,
  output logic [WIDTH_ID-1:0]  M_RID,
  output logic [WIDTH_DA-1:0]  M_RDATA,
  output logic [1:0]           M_RRESP,
  output logic                 M_RLAST,
  output logic                 M_RVALID,
  input  logic                 M_RREADY
);
  localparam int MH = WIDTH_ID + 1;
  localparam int ML = WIDTH_ID;
  localparam int IW = WIDTH_ID;
  localparam int DW = WIDTH_DA;

  logic [2:0] req_b, req_r;
  logic [2:0] gb, gr;
  logic       b_done, r_done;
  logic       unused_ok;

  // accept only beats carrying this master's MID
  assign req_b = {S2_BVALID & (S2_BID[MH:ML] == MASTER_ID),
                  S1_BVALID & (S1_BID[MH:ML] == MASTER_ID),
                  S0_BVALID & (S0_BID[MH:ML] == MASTER_ID)};
  assign req_r = {S2_RVALID & (S2_RID[MH:ML] == MASTER_ID),
                  S1_RVALID & (S1_RID[MH:ML] == MASTER_ID),
                  S0_RVALID & (S0_RID[MH:ML] == MASTER_ID)};

  assign b_done = M_BVALID & M_BREADY;
  assign r_done = M_RVALID & M_RREADY & M_RLAST;

  axi_stom_s3_arb u_arb_b (
    .clk   (ACLK),
    .rst   (ARESET),
    .req   (req_b),
    .done  (b_done),
    .grant (gb)
  );

  axi_stom_s3_arb u_arb_r (
    .clk   (ACLK),
    .rst   (ARESET),
    .req   (req_r),
    .done  (r_done),
    .grant (gr)
  );

  assign M_BID =
      ({IW{gb[0]}} & S0_BID[IW-1:0])
    | ({IW{gb[1]}} & S1_BID[IW-1:0])
    | ({IW{gb[2]}} & S2_BID[IW-1:0]);
  assign M_BRESP =
      ({2{gb[0]}} & S0_BRESP)
    | ({2{gb[1]}} & S1_BRESP)
    | ({2{gb[2]}} & S2_BRESP);
  assign M_BVALID = (gb[0] & S0_BVALID)
                  | (gb[1] & S1_BVALID)
                  | (gb[2] & S2_BVALID);

  assign M_RID =
      ({IW{gr[0]}} & S0_RID[IW-1:0])
    | ({IW{gr[1]}} & S1_RID[IW-1:0])
    | ({IW{gr[2]}} & S2_RID[IW-1:0]);
  assign M_RDATA =
      ({DW{gr[0]}} & S0_RDATA)
    | ({DW{gr[1]}} & S1_RDATA)
    | ({DW{gr[2]}} & S2_RDATA);
  assign M_RRESP =
      ({2{gr[0]}} & S0_RRESP)
    | ({2{gr[1]}} & S1_RRESP)
    | ({2{gr[2]}} & S2_RRESP);
  assign M_RLAST = (gr[0] & S0_RLAST)
                 | (gr[1] & S1_RLAST)
                 | (gr[2] & S2_RLAST);
  assign M_RVALID = (gr[0] & S0_RVALID)
                  | (gr[1] & S1_RVALID)
                  | (gr[2] & S2_RVALID);

  assign S0_BREADY = gb[0] & M_BREADY;
  assign S1_BREADY = gb[1] & M_BREADY;
  assign S2_BREADY = gb[2] & M_BREADY;
  assign S0_RREADY = gr[0] & M_RREADY;
  assign S1_RREADY = gr[1] & M_RREADY;
  assign S2_RREADY = gr[2] & M_RREADY;

  // slave-code bits are routing info not needed on this side
  assign unused_ok = ^{S0_BID[WIDTH_SID-1:MH+1],
                       S1_BID[WIDTH_SID-1:MH+1],
                       S2_BID[WIDTH_SID-1:MH+1],
                       S0_RID[WIDTH_SID-1:MH+1],
                       S1_RID[WIDTH_SID-1:MH+1],
                       S2_RID[WIDTH_SID-1:MH+1]};
endmodule

// File: tb/tb_axi_stom_s3.sv
// Directed bench for axi_stom_s3 with in-order B/R scoreboards.
// Expected beats are queued at drive time and popped on handshake.

module tb_axi_stom_s3;
  localparam logic [1:0] MID = 2'b01;

  logic ACLK = 1'b0;
  logic ARESET = 1'b1;
  logic [7:0]  S0_BID, S1_BID, S2_BID;
  logic [1:0]  S0_BRESP, S1_BRESP, S2_BRESP;
  logic        S0_BVALID, S1_BVALID, S2_BVALID;
  logic        S0_BREADY, S1_BREADY, S2_BREADY;
  logic [7:0]  S0_RID, S1_RID, S2_RID;
  logic [31:0] S0_RDATA, S1_RDATA, S2_RDATA;
  logic [1:0]  S0_RRESP, S1_RRESP, S2_RRESP;
  logic        S0_RLAST, S1_RLAST, S2_RLAST;
  logic        S0_RVALID, S1_RVALID, S2_RVALID;
  logic        S0_RREADY, S1_RREADY, S2_RREADY;
  logic [3:0]  M_BID, M_RID;
  logic [1:0]  M_BRESP, M_RRESP;
  logic        M_BVALID, M_BREADY;
  logic [31:0] M_RDATA;
  logic        M_RLAST, M_RVALID, M_RREADY;

  int n_chk = 0;
  int n_fail = 0;

  logic [5:0]  b_q[$];
  logic [38:0] r_q[$];
  logic [5:0]  eb;
  logic [38:0] er;

  always #5 ACLK = ~ACLK;

  axi_stom_s3 #(.MASTER_ID(MID)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S0_BID(S0_BID), .S0_BRESP(S0_BRESP),
    .S0_BVALID(S0_BVALID), .S0_BREADY(S0_BREADY),
    .S0_RID(S0_RID), .S0_RDATA(S0_RDATA),
    .S0_RRESP(S0_RRESP), .S0_RLAST(S0_RLAST),
    .S0_RVALID(S0_RVALID), .S0_RREADY(S0_RREADY),
    .S1_BID(S1_BID), .S1_BRESP(S1_BRESP),
    .S1_BVALID(S1_BVALID), .S1_BREADY(S1_BREADY),
    .S1_RID(S1_RID), .S1_RDATA(S1_RDATA),
    .S1_RRESP(S1_RRESP), .S1_RLAST(S1_RLAST),
    .S1_RVALID(S1_RVALID), .S1_RREADY(S1_RREADY),
    .S2_BID(S2_BID), .S2_BRESP(S2_BRESP),
    .S2_BVALID(S2_BVALID), .S2_BREADY(S2_BREADY),
    .S2_RID(S2_RID), .S2_RDATA(S2_RDATA),
    .S2_RRESP(S2_RRESP), .S2_RLAST(S2_RLAST),
    .S2_RVALID(S2_RVALID), .S2_RREADY(S2_RREADY),
    .M_BID(M_BID), .M_BRESP(M_BRESP),
    .M_BVALID(M_BVALID), .M_BREADY(M_BREADY),
    .M_RID(M_RID), .M_RDATA(M_RDATA),
    .M_RRESP(M_RRESP), .M_RLAST(M_RLAST),
    .M_RVALID(M_RVALID), .M_RREADY(M_RREADY)
  );

  function automatic logic [7:0] sid(
    input logic [1:0] sc, input logic [1:0] m,
    input logic [3:0] id);
    return {sc, m, id};
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic clear_in();
    S0_BID = '0; S1_BID = '0; S2_BID = '0;
    S0_BRESP = '0; S1_BRESP = '0; S2_BRESP = '0;
    S0_BVALID = 0; S1_BVALID = 0; S2_BVALID = 0;
    S0_RID = '0; S1_RID = '0; S2_RID = '0;
    S0_RDATA = '0; S1_RDATA = '0; S2_RDATA = '0;
    S0_RRESP = '0; S1_RRESP = '0; S2_RRESP = '0;
    S0_RLAST = 0; S1_RLAST = 0; S2_RLAST = 0;
    S0_RVALID = 0; S1_RVALID = 0; S2_RVALID = 0;
  endtask

  task automatic do_reset();
    clear_in();
    ARESET = 1'b1;
    step();
    step();
    ARESET = 1'b0;
  endtask

  // scoreboard: every master-side handshake must match the queue head
  always @(negedge ACLK) begin
    if (M_BVALID && M_BREADY) begin
      n_chk++;
      if (b_q.size() == 0) begin
        n_fail++;
        $error("FAIL b_extra observed=%0h expected=none",
               {M_BID, M_BRESP});
      end else begin
        eb = b_q.pop_front();
        assert ({M_BID, M_BRESP} === eb) else begin
          n_fail++;
          $error("FAIL b_beat observed=%0h expected=%0h",
                 {M_BID, M_BRESP}, eb);
        end
      end
    end
    if (M_RVALID && M_RREADY) begin
      n_chk++;
      if (r_q.size() == 0) begin
        n_fail++;
        $error("FAIL r_extra observed=%0h expected=none",
               {M_RID, M_RDATA, M_RRESP, M_RLAST});
      end else begin
        er = r_q.pop_front();
        assert ({M_RID, M_RDATA, M_RRESP, M_RLAST} === er)
        else begin
          n_fail++;
          $error("FAIL r_beat observed=%0h expected=%0h",
                 {M_RID, M_RDATA, M_RRESP, M_RLAST}, er);
        end
      end
    end
  end

  initial begin
    clear_in();
    M_BREADY = 1'b1;
    M_RREADY = 1'b1;
    ARESET = 1'b1;
    // live requests during reset must not leak through
    S1_BID = sid(2'b10, MID, 4'h5);
    S1_BVALID = 1;
    S0_RID = sid(2'b00, MID, 4'h1);
    S0_RDATA = 32'hdead_beef;
    S0_RLAST = 1;
    S0_RVALID = 1;
    @(negedge ACLK);
    chk("rst_bvalid", M_BVALID, 0);
    chk("rst_rvalid", M_RVALID, 0);
    chk("rst_rdata", M_RDATA, 0);
    chk("rst_s1_bready", S1_BREADY, 0);
    chk("rst_s0_rready", S0_RREADY, 0);
    step();
    clear_in();
    ARESET = 1'b0;
    step();

    // single B from S1
    S1_BID = sid(2'b10, MID, 4'h5);
    S1_BRESP = 2'b00;
    S1_BVALID = 1;
    b_q.push_back({4'h5, 2'b00});
    @(negedge ACLK);
    chk("single_bvalid", M_BVALID, 1);
    chk("single_bid", M_BID, 4'h5);
    chk("single_s1_bready", S1_BREADY, 1);
    chk("single_s0_bready", S0_BREADY, 0);
    step();
    // ptr is now 2: S2 wins over S0
    S1_BVALID = 0;
    S0_BID = sid(2'b00, MID, 4'hA);
    S0_BRESP = 2'b10;
    S0_BVALID = 1;
    S2_BID = sid(2'b11, MID, 4'hC);
    S2_BRESP = 2'b01;
    S2_BVALID = 1;
    b_q.push_back({4'hC, 2'b01});
    b_q.push_back({4'hA, 2'b10});
    @(negedge ACLK);
    chk("ptr2_s2_bready", S2_BREADY, 1);
    chk("ptr2_s0_bready", S0_BREADY, 0);
    step();
    S2_BVALID = 0;
    @(negedge ACLK);
    chk("ptr2_s0_next", S0_BREADY, 1);
    step();
    S0_BVALID = 0;

    // foreign MID is never forwarded
    S0_RID = sid(2'b00, 2'b10, 4'h3);
    S0_RDATA = 32'h0bad_0bad;
    S0_RLAST = 1;
    S0_RVALID = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge ACLK);
      chk("mid_rvalid", M_RVALID, 0);
      chk("mid_s0_rready", S0_RREADY, 0);
      step();
    end
    S0_RVALID = 0;

    // burst lock: S0 4 beats, S2 arrives at beat 2
    do_reset();
    for (int b = 0; b < 4; b++) begin
      S0_RID = sid(2'b00, MID, 4'h7);
      S0_RDATA = 32'h1000_0000 + 32'(b);
      S0_RRESP = 2'b00;
      S0_RLAST = (b == 3);
      S0_RVALID = 1;
      r_q.push_back({4'h7, 32'h1000_0000 + 32'(b),
                     2'b00, (b == 3)});
      if (b >= 2) begin
        S2_RID = sid(2'b10, MID, 4'h9);
        S2_RDATA = 32'h2222_0000;
        S2_RRESP = 2'b01;
        S2_RLAST = 1;
        S2_RVALID = 1;
      end
      @(negedge ACLK);
      chk("burst_s0_rready", S0_RREADY, 1);
      if (b >= 2) chk("burst_s2_blocked", S2_RREADY, 0);
      step();
    end
    S0_RVALID = 0;
    r_q.push_back({4'h9, 32'h2222_0000, 2'b01, 1'b1});
    @(negedge ACLK);
    chk("burst_s2_after", S2_RREADY, 1);
    step();
    S2_RVALID = 0;

    // round-robin over three continuous B requesters
    do_reset();
    S0_BID = sid(2'b00, MID, 4'h0);
    S1_BID = sid(2'b01, MID, 4'h1);
    S2_BID = sid(2'b10, MID, 4'h2);
    S0_BVALID = 1;
    S1_BVALID = 1;
    S2_BVALID = 1;
    for (int i = 0; i < 6; i++)
      b_q.push_back({4'(i % 3), 2'b00});
    for (int i = 0; i < 6; i++) begin
      @(negedge ACLK);
      step();
    end
    S0_BVALID = 0;
    S1_BVALID = 0;
    S2_BVALID = 0;
    @(negedge ACLK);
    chk("rr_drained", b_q.size(), 0);

    // backpressure mid-burst from S1
    do_reset();
    S1_RID = sid(2'b01, MID, 4'h3);
    S1_RDATA = 32'h3300_0000;
    S1_RLAST = 0;
    S1_RVALID = 1;
    r_q.push_back({4'h3, 32'h3300_0000, 2'b00, 1'b0});
    @(negedge ACLK);
    step();
    S1_RDATA = 32'h3300_0001;
    r_q.push_back({4'h3, 32'h3300_0001, 2'b00, 1'b0});
    M_RREADY = 0;
    S0_RID = sid(2'b00, MID, 4'hE);
    S0_RDATA = 32'h0000_4444;
    S0_RLAST = 1;
    S0_RVALID = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge ACLK);
      chk("bp_rdata", M_RDATA, 32'h3300_0001);
      chk("bp_rid", M_RID, 4'h3);
      chk("bp_rvalid", M_RVALID, 1);
      chk("bp_s1_rready", S1_RREADY, 0);
      chk("bp_s0_rready", S0_RREADY, 0);
      step();
    end
    M_RREADY = 1;
    @(negedge ACLK);
    chk("bp_resume", S1_RREADY, 1);
    step();
    S1_RDATA = 32'h3300_0002;
    r_q.push_back({4'h3, 32'h3300_0002, 2'b00, 1'b0});
    @(negedge ACLK);
    step();
    S1_RDATA = 32'h3300_0003;
    S1_RLAST = 1;
    r_q.push_back({4'h3, 32'h3300_0003, 2'b00, 1'b1});
    @(negedge ACLK);
    step();
    S1_RVALID = 0;
    r_q.push_back({4'hE, 32'h0000_4444, 2'b00, 1'b1});
    @(negedge ACLK);
    chk("bp_s0_after", S0_RREADY, 1);
    step();
    S0_RVALID = 0;

    // reset mid-burst; restart must use ptr 0
    do_reset();
    S1_RID = sid(2'b01, MID, 4'h1);
    S1_RDATA = 32'h5555_0001;
    S1_RLAST = 1;
    S1_RVALID = 1;
    r_q.push_back({4'h1, 32'h5555_0001, 2'b00, 1'b1});
    @(negedge ACLK);
    step();
    S1_RVALID = 0;
    S2_RID = sid(2'b10, MID, 4'h6);
    S2_RDATA = 32'h6600_0000;
    S2_RLAST = 0;
    S2_RVALID = 1;
    r_q.push_back({4'h6, 32'h6600_0000, 2'b00, 1'b0});
    @(negedge ACLK);
    step();
    S2_RDATA = 32'h6600_0001;
    r_q.push_back({4'h6, 32'h6600_0001, 2'b00, 1'b0});
    @(negedge ACLK);
    step();
    S2_RDATA = 32'h6600_0002;
    ARESET = 1'b1;
    @(negedge ACLK);
    chk("rstm_rvalid", M_RVALID, 0);
    chk("rstm_rdata", M_RDATA, 0);
    chk("rstm_rid", M_RID, 0);
    chk("rstm_s2_rready", S2_RREADY, 0);
    step();
    ARESET = 1'b0;
    S1_RDATA = 32'h5555_0002;
    S1_RVALID = 1;
    S2_RDATA = 32'h6600_00ff;
    S2_RLAST = 1;
    r_q.push_back({4'h1, 32'h5555_0002, 2'b00, 1'b1});
    @(negedge ACLK);
    chk("rstm_s1_first", S1_RREADY, 1);
    chk("rstm_s2_wait", S2_RREADY, 0);
    step();
    S1_RVALID = 0;
    r_q.push_back({4'h6, 32'h6600_00ff, 2'b00, 1'b1});
    @(negedge ACLK);
    chk("rstm_s2_next", S2_RREADY, 1);
    step();
    S2_RVALID = 0;

    step();
    @(negedge ACLK);
    chk("b_q_empty", b_q.size(), 0);
    chk("r_q_empty", r_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
